// File: rtl/mips_pkg.sv
// Shared encodings, CP0 layout and address defaults for the single-cycle MIPS-I subset core.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ERET    = 6'h18;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [4:0] CP0_MF     = 5'h00;
    localparam logic [4:0] CP0_MT     = 5'h04;
    localparam logic [4:0] CP0_SR     = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned SR_IE     = 0;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IM2    = 12;
    localparam int unsigned CAUSE_IP2 = 12;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW,
        I_BEQ, I_J, I_JAL, I_MFC0, I_MTC0, I_ERET
    } instr_e;

    // Anything not listed decodes to I_NOP.
    function automatic instr_e decode(input logic [5:0] opcode, input logic [4:0] rs,
                                      input logic [5:0] funct);
        instr_e kind;
        kind = I_NOP;
        case (opcode)
            OP_SPECIAL:
                case (funct)
                    FN_ADDU: kind = I_ADDU;
                    FN_SUBU: kind = I_SUBU;
                    FN_JR:   kind = I_JR;
                    default: ;
                endcase
            OP_ORI:  kind = I_ORI;
            OP_LUI:  kind = I_LUI;
            OP_LW:   kind = I_LW;
            OP_SW:   kind = I_SW;
            OP_BEQ:  kind = I_BEQ;
            OP_J:    kind = I_J;
            OP_JAL:  kind = I_JAL;
            OP_COP0:
                if (rs[4] && funct == FN_ERET) kind = I_ERET;
                else if (rs == CP0_MF)         kind = I_MFC0;
                else if (rs == CP0_MT)         kind = I_MTC0;
            default: ;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/mips_cp0.sv
// Minimal coprocessor 0: SR, Cause and EPC, interrupt request qualification and eret.
module mips_cp0 import mips_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        we,
    input  logic        eret,
    input  logic [4:0]  sel,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        irq
);

    logic [31:0] sr;
    logic [31:0] cause;

    assign irq = interrupt && sr[SR_IM2] && sr[SR_IE] && !sr[SR_EXL];

    always_comb begin
        rdata = '0;
        case (sel)
            CP0_SR:    rdata = sr;
            CP0_CAUSE: rdata = cause;
            CP0_EPC:   rdata = epc;
            default:   ;
        endcase
    end

    // Cause is rebuilt from the pin every edge, so mtc0 to it never sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            cause <= '0;
            epc   <= '0;
        end else begin
            cause <= 32'(interrupt) << CAUSE_IP2;
            if (irq) begin
                epc        <= pc;
                sr[SR_EXL] <= 1'b1;
            end else if (eret) begin
                sr[SR_EXL] <= 1'b0;
            end else if (we) begin
                case (sel)
                    CP0_SR:  sr  <= wdata;
                    CP0_EPC: epc <= wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-I subset CPU with internal ROM, GPR file, data RAM and CP0; exports the PC.
module mips_cpu import mips_pkg::*; #(
  parameter int unsigned IM_WORDS  = 1024,
  parameter int unsigned DM_WORDS  = 1024,
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter string       IM_FILE   = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] addr
);

  localparam int unsigned IM_AW = $clog2(IM_WORDS);
  localparam int unsigned DM_AW = $clog2(DM_WORDS);

  logic [31:0] im  [IM_WORDS];
  logic [31:0] dm  [DM_WORDS];
  logic [31:0] gpr [32];

  logic [31:0] pc, pc_plus4, pc_next, ir, simm, ea;
  logic [31:0] rs_val, rt_val, wb_data, cp0_rdata, epc;
  logic [4:0]  rs, rt, rd, wb_reg;
  logic [15:0] imm;
  logic [IM_AW-1:0] im_idx;
  logic [DM_AW-1:0] dm_idx;
  logic        wb_en, dm_we, cp0_we, eret, irq;
  instr_e      kind;

  assign addr     = pc;
  assign im_idx   = IM_AW'(((pc - PC_RESET) >> 2) % IM_WORDS);
  assign ir       = im[im_idx];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm      = ir[15:0];
  assign simm     = {{16{imm[15]}}, imm};
  assign kind     = decode(ir[31:26], rs, ir[5:0]);
  assign rs_val   = gpr[rs];
  assign rt_val   = gpr[rt];
  assign pc_plus4 = pc + 32'd4;
  assign ea       = rs_val + simm;
  assign dm_idx   = DM_AW'((ea >> 2) % DM_WORDS);

  always_comb begin
    pc_next = pc_plus4;
    wb_en   = 1'b0;
    wb_reg  = rt;
    wb_data = '0;
    dm_we   = 1'b0;
    cp0_we  = 1'b0;
    eret    = 1'b0;
    case (kind)
      I_ADDU: begin wb_en = 1'b1; wb_reg = rd; wb_data = rs_val + rt_val; end
      I_SUBU: begin wb_en = 1'b1; wb_reg = rd; wb_data = rs_val - rt_val; end
      I_JR:   pc_next = rs_val;
      I_ORI:  begin wb_en = 1'b1; wb_data = rs_val | {16'h0000, imm}; end
      I_LUI:  begin wb_en = 1'b1; wb_data = {imm, 16'h0000}; end
      I_LW:   begin wb_en = 1'b1; wb_data = dm[dm_idx]; end
      I_SW:   dm_we = 1'b1;
      I_BEQ:  if (rs_val == rt_val) pc_next = pc_plus4 + (simm << 2);
      I_J:    pc_next = {pc[31:28], ir[25:0], 2'b00};
      I_JAL:  begin
        pc_next = {pc[31:28], ir[25:0], 2'b00};
        wb_en   = 1'b1;
        wb_reg  = 5'd31;
        wb_data = pc_plus4;
      end
      I_MFC0: begin wb_en = 1'b1; wb_data = cp0_rdata; end
      I_MTC0: cp0_we = 1'b1;
      I_ERET: begin eret = 1'b1; pc_next = epc; end
      default: ;
    endcase
  end

  mips_cp0 u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .we        (cp0_we),
    .eret      (eret),
    .sel       (rd),
    .wdata     (rt_val),
    .pc        (pc),
    .rdata     (cp0_rdata),
    .epc       (epc),
    .irq       (irq)
  );

  // An accepted interrupt squashes every architectural write of this instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_RESET;
      for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      pc <= irq ? EXC_ENTRY : pc_next;
      if (wb_en && !irq && wb_reg != 5'd0) gpr[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (dm_we && !irq) begin
      dm[dm_idx] <= rt_val;
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: instruction-level reference model run in lockstep, directed and random programs.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt = 1'b0;
    logic [31:0] addr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] prog  [1024];
    logic [31:0] m_gpr [32];
    logic [31:0] m_dm  [1024];
    logic [31:0] m_pc, m_sr, m_cause, m_epc;

    mips_cpu #(
        .IM_WORDS  (1024),
        .DM_WORDS  (1024),
        .PC_RESET  (32'h0000_3000),
        .EXC_ENTRY (32'h0000_4180),
        .IM_FILE   ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .addr      (addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    function automatic logic [31:0] enc_c0(input logic [4:0] sub, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h10, sub, rt, rd, 11'h000};
    endfunction

    function automatic void put(input logic [31:0] a, input logic [31:0] w);
        prog[((a - 32'h3000) >> 2) % 1024] = w;
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) dut.im[i] = prog[i];
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_pc = 32'h0000_3000;
        m_sr = '0; m_cause = '0; m_epc = '0;
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        for (int i = 0; i < 1024; i++) m_dm[i] = '0;
    endfunction

    function automatic void wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_gpr[r] = v;
    endfunction

    function automatic logic [31:0] cp0_read(input logic [4:0] r);
        if (r == 5'd12) return m_sr;
        if (r == 5'd13) return m_cause;
        if (r == 5'd14) return m_epc;
        return 32'h0;
    endfunction

    function automatic void model_step(input logic intr);
        logic [31:0] ins, a, b, npc, simm, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        ins  = prog[((m_pc - 32'h3000) >> 2) % 1024];
        op   = ins[31:26]; fn = ins[5:0];
        rs   = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        a    = m_gpr[rs];  b  = m_gpr[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        ea   = a + simm;
        npc  = m_pc + 32'd4;
        if (intr && m_sr[12] && m_sr[0] && !m_sr[1]) begin
            m_epc  = m_pc;
            m_sr[1] = 1'b1;
            m_pc   = 32'h0000_4180;
        end else begin
            case (op)
                6'h00: begin
                    if (fn == 6'h21)      wr(rd, a + b);
                    else if (fn == 6'h23) wr(rd, a - b);
                    else if (fn == 6'h08) npc = a;
                end
                6'h0d: wr(rt, a | {16'h0, ins[15:0]});
                6'h0f: wr(rt, {ins[15:0], 16'h0});
                6'h23: wr(rt, m_dm[(ea >> 2) % 1024]);
                6'h2b: m_dm[(ea >> 2) % 1024] = b;
                6'h04: if (a == b) npc = m_pc + 32'd4 + (simm << 2);
                6'h02: npc = {m_pc[31:28], ins[25:0], 2'b00};
                6'h03: begin wr(5'd31, m_pc + 32'd4); npc = {m_pc[31:28], ins[25:0], 2'b00}; end
                6'h10: begin
                    if (ins[25] && fn == 6'h18) begin npc = m_epc; m_sr[1] = 1'b0; end
                    else if (rs == 5'd0) wr(rt, cp0_read(rd));
                    else if (rs == 5'd4) begin
                        if (rd == 5'd12)      m_sr  = b;
                        else if (rd == 5'd14) m_epc = b;
                    end
                end
                default: ;
            endcase
            m_pc = npc;
        end
        m_cause = intr ? 32'h0000_1000 : 32'h0;
    endfunction

    // ---------------- comparison ----------------
    task automatic compare_all();
        check("addr", addr, m_pc);
        check("sr", dut.u_cp0.sr, m_sr);
        check("cause", dut.u_cp0.cause, m_cause);
        check("epc", dut.u_cp0.epc, m_epc);
        for (int i = 0; i < 32; i++) check($sformatf("gpr%0d", i), dut.gpr[i], m_gpr[i]);
    endtask

    task automatic check_dm();
        for (int i = 0; i < 1024; i++) check($sformatf("dm%0d", i), dut.dm[i], m_dm[i]);
    endtask

    task automatic tick();
        model_step(interrupt);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_reset_addr", addr, 32'h0000_3000);
        check("mid_reset_gpr3", dut.gpr[3], 32'h0);
        check("mid_reset_dm1", dut.dm[1], 32'h0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          off;
        int unsigned k;
        rs  = 5'($urandom_range(0, 7));
        rt  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        rd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        imm = 16'($urandom);
        k   = $urandom_range(0, 99);
        if (k < 12) return enc_r(6'h21, rs, rt, rd);
        if (k < 22) return enc_r(6'h23, rs, rt, rd);
        if (k < 34) return enc_i(6'h0d, rs, rt, ($urandom_range(0, 2) == 0) ? 16'h1001 : imm);
        if (k < 40) return enc_i(6'h0f, rs, rt, imm);
        if (k < 50) return enc_i(6'h23, ($urandom_range(0, 1) == 0) ? 5'd0 : rs, rt,
                                 16'($urandom_range(0, 63) << 2));
        if (k < 60) return enc_i(6'h2b, ($urandom_range(0, 1) == 0) ? 5'd0 : rs, rt,
                                 16'($urandom_range(0, 63) << 2));
        if (k < 68) begin
            off = int'($urandom_range(0, 12)) - 4;
            return enc_i(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, 16'(off));
        end
        if (k < 71) return enc_j(6'h02, 32'h3000 + ($urandom_range(0, 1023) << 2));
        if (k < 74) return enc_j(6'h03, 32'h3000 + ($urandom_range(0, 1023) << 2));
        if (k < 76) return enc_r(6'h08, ($urandom_range(0, 1) == 0) ? 5'd31 : rs, 5'd0, 5'd0);
        if (k < 83) return enc_c0(5'd4, rt, 5'd12 + 5'($urandom_range(0, 3)));
        if (k < 89) return enc_c0(5'd0, rt, 5'd11 + 5'($urandom_range(0, 3)));
        if (k < 93) return 32'h4200_0018;
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] prev;
        logic        handled;

        for (int i = 0; i < 1024; i++) prog[i] = '0;
        put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h0005));
        put(32'h3004, enc_i(6'h0f, 5'd0, 5'd2, 16'h0001));
        put(32'h3008, enc_r(6'h21, 5'd1, 5'd2, 5'd3));
        put(32'h300c, enc_r(6'h23, 5'd1, 5'd2, 5'd4));
        put(32'h3010, enc_i(6'h2b, 5'd0, 5'd3, 16'h0004));
        put(32'h3014, enc_i(6'h23, 5'd0, 5'd5, 16'h0004));
        put(32'h3018, enc_i(6'h04, 5'd0, 5'd0, 16'h0001));
        put(32'h301c, enc_i(6'h0d, 5'd0, 5'd6, 16'hdead));
        put(32'h3020, enc_j(6'h03, 32'h3030));
        put(32'h3030, enc_i(6'h0d, 5'd0, 5'd7, 16'h1001));
        put(32'h3034, enc_c0(5'd4, 5'd7, 5'd12));
        put(32'h3038, enc_i(6'h0d, 5'd0, 5'd8, 16'h0055));
        put(32'h303c, enc_i(6'h0d, 5'd0, 5'd7, 16'h1000));
        put(32'h3040, enc_c0(5'd4, 5'd7, 5'd12));
        put(32'h3044, enc_i(6'h0d, 5'd0, 5'd11, 16'h0077));
        put(32'h3048, 32'hfc00_0000);
        put(32'h304c, enc_j(6'h02, 32'h304c));
        put(32'h4180, enc_i(6'h0d, 5'd0, 5'd9, 16'h0001));
        put(32'h4184, enc_c0(5'd0, 5'd10, 5'd13));
        put(32'h4188, 32'h4200_0018);
        load_rom();
        model_reset();

        #12 reset = 1'b1;
        #1;
        check("reset_addr", addr, 32'h0000_3000);
        check("reset_gpr3", dut.gpr[3], 32'h0);
        compare_all();

        handled = 1'b0;
        for (int c = 0; c < 26; c++) begin
            interrupt = (m_pc == 32'h3038 && !handled) || m_pc == 32'h4180 ||
                        m_pc == 32'h4184 || m_pc == 32'h3044 || m_pc == 32'h3048;
            prev = m_pc;
            tick();
            if (c < 2) check("boot_seq", addr, 32'h3004 + 32'(c) * 32'd4);
            if (prev == 32'h3038 && !handled) begin
                check("irq_vector", addr, 32'h0000_4180);
                check("irq_epc", dut.u_cp0.epc, 32'h0000_3038);
                check("irq_sr", dut.u_cp0.sr, 32'h0000_1003);
                check("irq_cause", dut.u_cp0.cause, 32'h0000_1000);
                check("irq_squash", dut.gpr[8], 32'h0);
                handled = 1'b1;
            end
            if (prev == 32'h4180) check("exl_mask", addr, 32'h0000_4184);
            if (prev == 32'h4188) begin
                check("eret_pc", addr, 32'h0000_3038);
                check("eret_sr", dut.u_cp0.sr, 32'h0000_1001);
            end
            if (prev == 32'h3044) check("ie_mask", addr, 32'h0000_3048);
            if (prev == 32'h3048) check("undef_pc", addr, 32'h0000_304c);
        end
        check("addu", dut.gpr[3], 32'h0001_0005);
        check("subu", dut.gpr[4], 32'hffff_0005);
        check("lw", dut.gpr[5], 32'h0001_0005);
        check("beq_skip", dut.gpr[6], 32'h0);
        check("jal_link", dut.gpr[31], 32'h0000_3024);
        check("reexec", dut.gpr[8], 32'h0000_0055);
        check("handler", dut.gpr[9], 32'h0000_0001);
        check("mfc0_cause", dut.gpr[10], 32'h0000_1000);
        check("masked_run", dut.gpr[11], 32'h0000_0077);
        check("sw", dut.dm[1], 32'h0001_0005);
        check("loop_pc", addr, 32'h0000_304c);
        check_dm();
        reset_pulse();

        for (int p = 0; p < 2; p++) begin
            reset = 1'b0;
            #1;
            for (int i = 0; i < 1024; i++) prog[i] = rand_instr();
            load_rom();
            model_reset();
            interrupt = 1'b0;
            @(posedge clk);
            #1;
            compare_all();
            reset = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 7) == 0) interrupt = ~interrupt;
                tick();
                if (c == 700) reset_pulse();
            end
            check_dm();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
